// File: rtl/route_pkg.sv
// Shared types for the route sequencer: command encodings, queued command payload,
// sequencer state and fault codes.
package route_pkg;

    typedef enum logic [1:0] {
        DIR_STOP  = 2'b00,
        DIR_LEFT  = 2'b01,
        DIR_RIGHT = 2'b10,
        DIR_RSVD  = 2'b11
    } dir_e;

    typedef struct packed {
        dir_e       dir;
        logic [1:0] count;
    } route_cmd_t;

    localparam int unsigned CMD_W = $bits(route_cmd_t);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_RUN   = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4,
        ST_FAULT = 3'd5
    } seq_state_e;

    localparam logic [1:0] FC_NONE     = 2'd0;
    localparam logic [1:0] FC_RSVD_DIR = 2'd1;
    localparam logic [1:0] FC_MOD_ERR  = 2'd2;
    localparam logic [1:0] FC_TIMEOUT  = 2'd3;

endpackage

// File: rtl/route_cmd_fifo.sv
// Route command queue: DEPTH entries of {dir,count}, head visible combinationally,
// synchronous flush. A push while full is refused even if a pop happens that cycle.
module route_cmd_fifo
    import route_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_push,
    input  route_cmd_t i_data,
    input  logic       i_pop,
    input  logic       i_flush,
    output route_cmd_t o_head,
    output logic       o_full,
    output logic       o_empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    route_cmd_t       r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;

    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_level == (AW+1)'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_head  = r_mem[r_rd_ptr];

    assign w_push = i_push && !o_full && !i_flush;
    assign w_pop  = i_pop && !o_empty && !i_flush;

    // Storage is not reset; validity is tracked by the level counter.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/turn_sequencer.sv
// Initiator for the turn-module enable/done handshake: walks a queued route, enables one
// turn module per step, waits for done, enforces an idle gap, and latches faults.
module turn_sequencer
    import route_pkg::*;
#(
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned TIMEOUT_CYC = 50000000,
    parameter int unsigned GAP_CYC     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_dir,
    input  logic [1:0] cmd_count,
    input  logic       go,
    input  logic       abort,
    input  logic       doneL,
    input  logic       doneR,
    input  logic       errL,
    input  logic       errR,
    output logic       enL,
    output logic       enR,
    output logic [1:0] count,
    output logic       busy,
    output logic       route_done,
    output logic       fault,
    output logic [1:0] fault_code
);

    localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int unsigned GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    seq_state_e  r_state;
    dir_e        r_dir;
    logic        r_en_l;
    logic        r_en_r;
    logic [1:0]  r_count;
    logic        r_busy;
    logic        r_route_done;
    logic        r_fault;
    logic [1:0]  r_fault_code;
    logic [TW-1:0] r_timer;
    logic [GW-1:0] r_gap_cnt;

    route_cmd_t  w_head;
    route_cmd_t  w_push_data;
    logic        w_full;
    logic        w_empty;
    logic        w_pop;
    logic        w_done_act;
    logic        w_err_act;

    assign w_push_data = '{dir: dir_e'(cmd_dir), count: cmd_count};
    assign w_pop       = (r_state == ST_FETCH) && !w_empty && !abort;

    // Only the module currently being driven may end or fail the step.
    assign w_done_act = (r_dir == DIR_LEFT) ? doneL : doneR;
    assign w_err_act  = (r_dir == DIR_LEFT) ? errL  : errR;

    route_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (cmd_valid),
        .i_data  (w_push_data),
        .i_pop   (w_pop),
        .i_flush (abort),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_dir        <= DIR_STOP;
            r_en_l       <= 1'b0;
            r_en_r       <= 1'b0;
            r_count      <= 2'd0;
            r_busy       <= 1'b0;
            r_route_done <= 1'b0;
            r_fault      <= 1'b0;
            r_fault_code <= FC_NONE;
            r_timer      <= '0;
            r_gap_cnt    <= '0;
        end else if (abort) begin
            // Count is deliberately held: it only changes on a step fetch.
            r_state      <= ST_IDLE;
            r_en_l       <= 1'b0;
            r_en_r       <= 1'b0;
            r_busy       <= 1'b0;
            r_route_done <= 1'b0;
            r_fault      <= 1'b0;
            r_fault_code <= FC_NONE;
            r_timer      <= '0;
            r_gap_cnt    <= '0;
        end else begin
            r_route_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (go && !w_empty) begin
                        r_state <= ST_FETCH;
                        r_busy  <= 1'b1;
                    end
                end

                ST_FETCH: begin
                    if (!w_empty) begin
                        case (w_head.dir)
                            DIR_STOP: begin
                                r_state      <= ST_DONE;
                                r_busy       <= 1'b0;
                                r_route_done <= 1'b1;
                            end
                            DIR_RSVD: begin
                                r_state      <= ST_FAULT;
                                r_busy       <= 1'b0;
                                r_fault      <= 1'b1;
                                r_fault_code <= FC_RSVD_DIR;
                            end
                            default: begin
                                r_state <= ST_RUN;
                                r_dir   <= w_head.dir;
                                r_en_l  <= (w_head.dir == DIR_LEFT);
                                r_en_r  <= (w_head.dir == DIR_RIGHT);
                                r_count <= w_head.count;
                                r_timer <= '0;
                            end
                        endcase
                    end
                end

                // Priority: module error, then done, then timeout.
                ST_RUN: begin
                    if (w_err_act) begin
                        r_state      <= ST_FAULT;
                        r_en_l       <= 1'b0;
                        r_en_r       <= 1'b0;
                        r_busy       <= 1'b0;
                        r_fault      <= 1'b1;
                        r_fault_code <= FC_MOD_ERR;
                    end else if (w_done_act) begin
                        r_state   <= ST_GAP;
                        r_en_l    <= 1'b0;
                        r_en_r    <= 1'b0;
                        r_gap_cnt <= '0;
                    end else if (r_timer == TW'(TIMEOUT_CYC - 1)) begin
                        r_state      <= ST_FAULT;
                        r_en_l       <= 1'b0;
                        r_en_r       <= 1'b0;
                        r_busy       <= 1'b0;
                        r_fault      <= 1'b1;
                        r_fault_code <= FC_TIMEOUT;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end

                // Enables stay low long enough for the turn module to clear its state.
                ST_GAP: begin
                    if (r_gap_cnt == GW'(GAP_CYC - 1)) begin
                        r_state <= ST_FETCH;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end

                ST_DONE: begin
                    r_state <= ST_IDLE;
                end

                ST_FAULT: begin
                    r_state <= ST_FAULT;
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_en_l  <= 1'b0;
                    r_en_r  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready  = !w_full;
    assign enL        = r_en_l;
    assign enR        = r_en_r;
    assign count      = r_count;
    assign busy       = r_busy;
    assign route_done = r_route_done;
    assign fault      = r_fault;
    assign fault_code = r_fault_code;

endmodule
